// File: rtl/mem_bus_responder_if.sv
// Byte-serial CPU bus plus the simple synchronous memory port seen by mem_bus_responder.
// The slave modport is the responder; the master modport is the initiator/memory side.
interface mem_bus_responder_if;
    logic       req_i;
    logic       rd_i;
    logic       wr_i;
    logic [7:0] data_i;
    logic       ack_o;
    logic [7:0] data_o;
    logic       data_oe_o;
    logic [1:0] phase_o;
    logic [15:0] mem_addr_o;
    logic       mem_re_o;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic [7:0] mem_rdata_i;

    modport slave (
        input  req_i, rd_i, wr_i, data_i, mem_rdata_i,
        output ack_o, data_o, data_oe_o, phase_o,
        output mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req_i, rd_i, wr_i, data_i, mem_rdata_i,
        input  ack_o, data_o, data_oe_o, phase_o,
        input  mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side end of the byte-serial req/ack bus: collects address lo/hi and a data byte,
// then issues one read or write on a synchronous memory port and answers with ack.
module mem_bus_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int READ_LAT    = 1
) (
    input  logic clk,
    input  logic rst_n,
    mem_bus_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RDWAIT, ACK} state_t;

    logic req_s, rd_s, wr_s;

    // Control strobes cross from the initiator's clock; data_i is held stable while req is high.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign {req_s, rd_s, wr_s} = {bus.req_i, bus.rd_i, bus.wr_i};
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][2:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= {bus.req_i, bus.rd_i, bus.wr_i};
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign {req_s, rd_s, wr_s} = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        oe_q, oe_d;
    logic        re_q, re_d;
    logic        we_q, we_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            cnt_q   <= 2'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            ack_q   <= 1'b0;
            oe_q    <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            oe_q    <= oe_d;
            re_q    <= re_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        oe_d    = oe_q;
        re_d    = 1'b0;
        we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Dropping both rd and wr mid-transaction abandons the partial address.
                if (phase_q != 2'd0 && !rd_s && !wr_s) begin
                    phase_d = 2'd0;
                end else if (req_s) begin
                    case (phase_q)
                        2'd0: begin
                            addr_d[7:0] = bus.data_i;
                            ack_d       = 1'b1;
                            state_d     = ACK;
                        end
                        2'd1: begin
                            addr_d[15:8] = bus.data_i;
                            ack_d        = 1'b1;
                            state_d      = ACK;
                        end
                        2'd2: begin
                            if (rd_s) begin
                                re_d    = 1'b1;
                                cnt_d   = 2'(READ_LAT);
                                state_d = RDWAIT;
                            end else begin
                                wdata_d = bus.data_i;
                                we_d    = 1'b1;
                                ack_d   = 1'b1;
                                state_d = ACK;
                            end
                        end
                        default: phase_d = 2'd0;
                    endcase
                end
            end
            RDWAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = bus.mem_rdata_i;
                    oe_d    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    oe_d    = 1'b0;
                    phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack_o       = ack_q;
    assign bus.data_o      = rdata_q;
    assign bus.data_oe_o   = oe_q;
    assign bus.phase_o     = phase_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_re_o    = re_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: dut_a (READ_LAT=1) for the main protocol,
// dut_b (READ_LAT=3) for reset during a pending read; both see the same initiator.
module tb_mem_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, rd, wr;
    logic [7:0] data;
    logic       use_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mem_bus_responder_if bus_a ();
    mem_bus_responder_if bus_b ();

    assign bus_a.req_i  = req;
    assign bus_a.rd_i   = rd;
    assign bus_a.wr_i   = wr;
    assign bus_a.data_i = data;
    assign bus_b.req_i  = req;
    assign bus_b.rd_i   = rd;
    assign bus_b.wr_i   = wr;
    assign bus_b.data_i = data;

    mem_bus_responder #(.SYNC_STAGES(2), .READ_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    mem_bus_responder #(.SYNC_STAGES(2), .READ_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Behavioural synchronous memories; contents are preloaded while reset is held.
    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];
    logic [7:0] rdata_a = 8'h00;
    logic [7:0] pipe_b [3];

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_a[16'h1234] = 8'hA5;
            mem_a[16'h00FF] = 8'h3C;
            mem_a[16'h4000] = 8'hD2;
            mem_b[16'h2222] = 8'h6E;
        end else begin
            if (bus_a.mem_we_o) mem_a[bus_a.mem_addr_o] = bus_a.mem_wdata_o;
            if (bus_b.mem_we_o) mem_b[bus_b.mem_addr_o] = bus_b.mem_wdata_o;
        end
        if (bus_a.mem_re_o) rdata_a <= mem_a[bus_a.mem_addr_o];
        pipe_b[0] <= bus_b.mem_re_o ? mem_b[bus_b.mem_addr_o] : 8'h00;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    assign bus_a.mem_rdata_i = rdata_a;
    assign bus_b.mem_rdata_i = pipe_b[2];

    int re_a = 0, we_a = 0, re_b = 0, both_hi = 0;

    always @(posedge clk) begin
        if (bus_a.mem_re_o) re_a <= re_a + 1;
        if (bus_a.mem_we_o) we_a <= we_a + 1;
        if (bus_b.mem_re_o) re_b <= re_b + 1;
        if ((bus_a.mem_re_o && bus_a.mem_we_o) || (bus_b.mem_re_o && bus_b.mem_we_o))
            both_hi <= both_hi + 1;
    end

    logic       sel_ack, sel_oe;
    logic [7:0] sel_data;
    assign sel_ack  = use_b ? bus_b.ack_o     : bus_a.ack_o;
    assign sel_oe   = use_b ? bus_b.data_oe_o : bus_a.data_oe_o;
    assign sel_data = use_b ? bus_b.data_o    : bus_a.data_o;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Raise req with a byte; ack must still be low one edge before ack_edge and high at it.
    task automatic applyStimulus(input logic [7:0] b, input int ack_edge, input string tag);
        data = b;
        req  = 1'b1;
        repeat (ack_edge - 1) tick();
        checkOutput({tag, "_early"}, sel_ack, 1'b0);
        tick();
        checkOutput({tag, "_ack"}, sel_ack, 1'b1);
    endtask

    task automatic releaseReq(input string tag);
        req = 1'b0;
        repeat (2) tick();
        checkOutput({tag, "_hold"}, sel_ack, 1'b1);
        tick();
        checkOutput({tag, "_fall"}, sel_ack, 1'b0);
        checkOutput({tag, "_oe_fall"}, sel_oe, 1'b0);
    endtask

    int pr, pw;

    initial begin
        req = 1'b0; rd = 1'b0; wr = 1'b0; data = 8'h00; use_b = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("rst_ack",   bus_a.ack_o,       1'b0);
        checkOutput("rst_oe",    bus_a.data_oe_o,   1'b0);
        checkOutput("rst_data",  bus_a.data_o,      8'h00);
        checkOutput("rst_addr",  bus_a.mem_addr_o,  16'h0000);
        checkOutput("rst_phase", bus_a.phase_o,     2'd0);
        checkOutput("rst_re",    bus_a.mem_re_o,    1'b0);
        checkOutput("rst_we",    bus_a.mem_we_o,    1'b0);
        checkOutput("rst_wdata", bus_a.mem_wdata_o, 8'h00);
        rst_n = 1'b1;
        tick();

        $display("[TB] read 0x1234");
        rd = 1'b1;
        pr = re_a;
        applyStimulus(8'h34, 3, "rd1_lo");
        checkOutput("rd1_lo_phase", bus_a.phase_o, 2'd0);
        releaseReq("rd1_lo");
        checkOutput("rd1_phase1", bus_a.phase_o, 2'd1);
        applyStimulus(8'h12, 3, "rd1_hi");
        releaseReq("rd1_hi");
        checkOutput("rd1_addr", bus_a.mem_addr_o, 16'h1234);
        checkOutput("rd1_phase2", bus_a.phase_o, 2'd2);
        applyStimulus(8'h00, 5, "rd1_data");
        checkOutput("rd1_rdata", bus_a.data_o, 8'hA5);
        checkOutput("rd1_oe", bus_a.data_oe_o, 1'b1);
        checkOutput("rd1_re_pulses", re_a - pr, 1);
        releaseReq("rd1_data");
        checkOutput("rd1_phase0", bus_a.phase_o, 2'd0);
        rd = 1'b0;

        $display("[TB] write 0x5C to 0xBEEF");
        wr = 1'b1;
        pr = re_a;
        pw = we_a;
        applyStimulus(8'hEF, 3, "wr1_lo");
        releaseReq("wr1_lo");
        applyStimulus(8'hBE, 3, "wr1_hi");
        releaseReq("wr1_hi");
        applyStimulus(8'h5C, 3, "wr1_data");
        checkOutput("wr1_wdata", bus_a.mem_wdata_o, 8'h5C);
        checkOutput("wr1_oe", bus_a.data_oe_o, 1'b0);
        releaseReq("wr1_data");
        checkOutput("wr1_we_pulses", we_a - pw, 1);
        checkOutput("wr1_no_read", re_a - pr, 0);
        checkOutput("wr1_mem", mem_a[16'hBEEF], 8'h5C);
        wr = 1'b0;

        $display("[TB] back-to-back read 0x00FF, write 0x0100");
        rd = 1'b1;
        pr = re_a;
        pw = we_a;
        applyStimulus(8'hFF, 3, "b2b_rlo");
        releaseReq("b2b_rlo");
        applyStimulus(8'h00, 3, "b2b_rhi");
        releaseReq("b2b_rhi");
        checkOutput("b2b_raddr", bus_a.mem_addr_o, 16'h00FF);
        applyStimulus(8'h00, 5, "b2b_rdata");
        checkOutput("b2b_rdata_val", bus_a.data_o, 8'h3C);
        releaseReq("b2b_rdata");
        rd = 1'b0;
        wr = 1'b1;
        applyStimulus(8'h00, 3, "b2b_wlo");
        releaseReq("b2b_wlo");
        checkOutput("b2b_wphase1", bus_a.phase_o, 2'd1);
        applyStimulus(8'h01, 3, "b2b_whi");
        releaseReq("b2b_whi");
        checkOutput("b2b_waddr", bus_a.mem_addr_o, 16'h0100);
        checkOutput("b2b_wphase2", bus_a.phase_o, 2'd2);
        applyStimulus(8'h99, 3, "b2b_wdata");
        repeat (10) tick();
        checkOutput("b2b_held_ack", bus_a.ack_o, 1'b1);
        releaseReq("b2b_wdata");
        checkOutput("b2b_we_pulses", we_a - pw, 1);
        checkOutput("b2b_re_pulses", re_a - pr, 1);
        checkOutput("b2b_mem", mem_a[16'h0100], 8'h99);
        checkOutput("b2b_phase0", bus_a.phase_o, 2'd0);
        wr = 1'b0;

        $display("[TB] abort after address low byte");
        rd = 1'b1;
        pr = re_a;
        pw = we_a;
        applyStimulus(8'h77, 3, "ab_lo");
        releaseReq("ab_lo");
        checkOutput("ab_phase1", bus_a.phase_o, 2'd1);
        rd = 1'b0;
        repeat (2) tick();
        checkOutput("ab_phase_pending", bus_a.phase_o, 2'd1);
        tick();
        checkOutput("ab_phase0", bus_a.phase_o, 2'd0);
        checkOutput("ab_addr_kept", bus_a.mem_addr_o, 16'h0177);
        checkOutput("ab_no_strobe", (re_a - pr) + (we_a - pw), 0);
        rd = 1'b1;
        applyStimulus(8'h00, 3, "ab_rlo");
        releaseReq("ab_rlo");
        applyStimulus(8'h40, 3, "ab_rhi");
        releaseReq("ab_rhi");
        checkOutput("ab_addr", bus_a.mem_addr_o, 16'h4000);
        applyStimulus(8'h00, 5, "ab_rdata");
        checkOutput("ab_rdata_val", bus_a.data_o, 8'hD2);
        releaseReq("ab_rdata");
        rd = 1'b0;

        $display("[TB] reset during pending read, READ_LAT=3");
        use_b = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd = 1'b1;
        pr = re_b;
        applyStimulus(8'h22, 3, "rs_lo");
        releaseReq("rs_lo");
        applyStimulus(8'h22, 3, "rs_hi");
        releaseReq("rs_hi");
        data = 8'h00;
        req  = 1'b1;
        repeat (3) tick();
        checkOutput("rs_re_pulse", bus_b.mem_re_o, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rs_async_ack",   bus_b.ack_o,      1'b0);
        checkOutput("rs_async_re",    bus_b.mem_re_o,   1'b0);
        checkOutput("rs_async_addr",  bus_b.mem_addr_o, 16'h0000);
        checkOutput("rs_async_phase", bus_b.phase_o,    2'd0);
        checkOutput("rs_async_oe",    bus_b.data_oe_o,  1'b0);
        checkOutput("rs_async_data",  bus_b.data_o,     8'h00);
        req = 1'b0;
        rd  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checkOutput("rs_no_retrigger", re_b - pr, 1);
        checkOutput("rs_ack_idle", bus_b.ack_o, 1'b0);
        rd = 1'b1;
        applyStimulus(8'h22, 3, "rs2_lo");
        releaseReq("rs2_lo");
        applyStimulus(8'h22, 3, "rs2_hi");
        releaseReq("rs2_hi");
        applyStimulus(8'h00, 7, "rs2_data");
        checkOutput("rs2_rdata", sel_data, 8'h6E);
        checkOutput("rs2_oe", sel_oe, 1'b1);
        releaseReq("rs2_data");
        checkOutput("rs2_re_pulses", re_b - pr, 2);
        checkOutput("rs2_phase0", bus_b.phase_o, 2'd0);
        rd = 1'b0;

        checkOutput("no_re_we_overlap", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
